// File: rtl/egr_pkg.sv
// Shared definitions for the egress stream arbiter: width helper, default index
// width and the arbiter FSM state encoding.
package egr_pkg;

  // Ceiling log2 with a floor of 1 so a select field is never zero bits wide
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned NUM_IN_DEF = 4;
  localparam int unsigned IDX_W      = clog2(NUM_IN_DEF);

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACTIVE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/egr_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping modulo NUM_IN.
module egr_rr_pick
  import egr_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic              o_valid,
  output logic [IDX_W-1:0]  o_idx
);

  logic [2*NUM_IN-1:0] w_dbl;
  logic [NUM_IN-1:0]   w_rot;
  logic [IDX_W:0]      w_off;
  logic [IDX_W:0]      w_sum;

  // Rotate so the pointer position lands on bit 0
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[NUM_IN-1:0];

  // Scan high to low so the lowest rotated offset wins
  always_comb begin
    o_valid = 1'b0;
    w_off   = '0;
    for (int j = NUM_IN - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        o_valid = 1'b1;
        w_off   = (IDX_W+1)'(j);
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + w_off;
  assign o_idx = (w_sum >= (IDX_W+1)'(NUM_IN)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_IN))
                                                : IDX_W'(w_sum);

endmodule

// File: rtl/egr_stream_arbiter.sv
// Packet-level round-robin merge of NUM_IN AXI streams onto one egress stream;
// a granted packet passes through combinationally until its tlast is accepted.
module egr_stream_arbiter
  import egr_pkg::*;
#(
  parameter int unsigned NUM_IN         = 4,
  parameter int unsigned AXIS_BUS_WIDTH = 64,
  parameter int unsigned AXIS_ID_WIDTH  = 4
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [NUM_IN*AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
  input  logic [NUM_IN-1:0]                  axis_in_tuser,
  input  logic [NUM_IN*AXIS_BUS_WIDTH/8-1:0] axis_in_tkeep,
  input  logic [NUM_IN-1:0]                  axis_in_tlast,
  input  logic [NUM_IN-1:0]                  axis_in_tvalid,
  output logic [NUM_IN-1:0]                  axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]          axis_out_tdata,
  output logic                               axis_out_tuser,
  output logic [AXIS_ID_WIDTH-1:0]           axis_out_tid,
  output logic [AXIS_BUS_WIDTH/8-1:0]        axis_out_tkeep,
  output logic                               axis_out_tlast,
  output logic                               axis_out_tvalid,
  input  logic                               axis_out_tready,
  output logic [NUM_IN*32-1:0]               pkt_count
);

  localparam int unsigned GRANT_W = clog2(NUM_IN);
  localparam int unsigned KEEP_W  = AXIS_BUS_WIDTH / 8;
  localparam int unsigned CNT_W   = 32;

  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $error("egr_stream_arbiter: NUM_IN must be in 2..16");
  end
  if (AXIS_ID_WIDTH < GRANT_W) begin : g_bad_id_w
    $error("egr_stream_arbiter: AXIS_ID_WIDTH too narrow for NUM_IN");
  end
  if ((AXIS_BUS_WIDTH % 8) != 0) begin : g_bad_bus_w
    $error("egr_stream_arbiter: AXIS_BUS_WIDTH must be a multiple of 8");
  end

  arb_state_t                 r_state;
  arb_state_t                 w_state_nxt;
  logic [GRANT_W-1:0]         r_grant;
  logic [GRANT_W-1:0]         w_grant_nxt;
  logic [GRANT_W-1:0]         r_rr_ptr;
  logic [GRANT_W-1:0]         w_rr_ptr_nxt;
  logic [NUM_IN*CNT_W-1:0]    r_pkt_count;

  logic                       w_pick_valid;
  logic [GRANT_W-1:0]         w_pick_idx;

  logic [AXIS_BUS_WIDTH-1:0]  w_sel_tdata;
  logic [KEEP_W-1:0]          w_sel_tkeep;
  logic                       w_sel_tuser;
  logic                       w_sel_tlast;
  logic                       w_sel_tvalid;
  logic                       w_last_hs;

  egr_rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (GRANT_W)
  ) u_pick (
    .i_req   (axis_in_tvalid),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Select the granted input's beat
  always_comb begin
    w_sel_tdata  = '0;
    w_sel_tkeep  = '0;
    w_sel_tuser  = 1'b0;
    w_sel_tlast  = 1'b0;
    w_sel_tvalid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_grant == GRANT_W'(i)) begin
        w_sel_tdata  = axis_in_tdata[i*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
        w_sel_tkeep  = axis_in_tkeep[i*KEEP_W +: KEEP_W];
        w_sel_tuser  = axis_in_tuser[i];
        w_sel_tlast  = axis_in_tlast[i];
        w_sel_tvalid = axis_in_tvalid[i];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= ARB_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // IDLE spends one cycle arbitrating; ACTIVE is a pure pass-through of r_grant
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_rr_ptr_nxt    = r_rr_ptr;
    axis_in_tready  = '0;
    axis_out_tvalid = 1'b0;
    w_last_hs       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt = w_pick_idx;
          w_state_nxt = ARB_ACTIVE;
        end
      end
      ARB_ACTIVE: begin
        axis_out_tvalid = w_sel_tvalid;
        for (int i = 0; i < NUM_IN; i++) begin
          if (r_grant == GRANT_W'(i)) begin
            axis_in_tready[i] = axis_out_tready;
          end
        end
        if (w_sel_tvalid && axis_out_tready && w_sel_tlast) begin
          w_last_hs    = 1'b1;
          w_state_nxt  = ARB_IDLE;
          w_rr_ptr_nxt = (r_grant == GRANT_W'(NUM_IN - 1)) ? '0 : r_grant + GRANT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Per-input packet counters, free-running modulo 2^32
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_pkt_count <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (w_last_hs && (r_grant == GRANT_W'(i))) begin
          r_pkt_count[i*CNT_W +: CNT_W] <= r_pkt_count[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign axis_out_tdata = w_sel_tdata;
  assign axis_out_tkeep = w_sel_tkeep;
  assign axis_out_tuser = w_sel_tuser;
  assign axis_out_tlast = w_sel_tlast;
  assign axis_out_tid   = AXIS_ID_WIDTH'(r_grant);
  assign pkt_count      = r_pkt_count;

endmodule

// File: tb/tb_egr_stream_arbiter.sv
// Directed bench for egr_stream_arbiter: reset, single source, fairness, stalls,
// wrap-around search and counter wrap.
module tb_egr_stream_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned BW = 64;
  localparam int unsigned KW = BW / 8;
  localparam int unsigned IW = 4;

  logic              aclk;
  logic              areset;
  logic [N*BW-1:0]   in_tdata;
  logic [N-1:0]      in_tuser;
  logic [N*KW-1:0]   in_tkeep;
  logic [N-1:0]      in_tlast;
  logic [N-1:0]      in_tvalid;
  logic [N-1:0]      in_tready;
  logic [BW-1:0]     out_tdata;
  logic              out_tuser;
  logic [IW-1:0]     out_tid;
  logic [KW-1:0]     out_tkeep;
  logic              out_tlast;
  logic              out_tvalid;
  logic              out_tready;
  logic [N*32-1:0]   pkt_count;

  int n_chk;
  int n_err;
  logic [IW+BW:0] mon_q[$];

  egr_stream_arbiter #(
    .NUM_IN         (N),
    .AXIS_BUS_WIDTH (BW),
    .AXIS_ID_WIDTH  (IW)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .axis_in_tdata   (in_tdata),
    .axis_in_tuser   (in_tuser),
    .axis_in_tkeep   (in_tkeep),
    .axis_in_tlast   (in_tlast),
    .axis_in_tvalid  (in_tvalid),
    .axis_in_tready  (in_tready),
    .axis_out_tdata  (out_tdata),
    .axis_out_tuser  (out_tuser),
    .axis_out_tid    (out_tid),
    .axis_out_tkeep  (out_tkeep),
    .axis_out_tlast  (out_tlast),
    .axis_out_tvalid (out_tvalid),
    .axis_out_tready (out_tready),
    .pkt_count       (pkt_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Record every accepted output beat
  always @(posedge aclk) begin
    if (!areset && out_tvalid && out_tready) begin
      mon_q.push_back({out_tid, out_tlast, out_tdata});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [BW-1:0] mk(input int src, input int beat);
    return {16'hC0DE, 8'(src), 24'h0, 8'(8'h30 + beat), 8'(beat)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [BW-1:0] d, input logic l);
    in_tdata[i*BW +: BW] = d;
    in_tkeep[i*KW +: KW] = d[15:8];
    in_tuser[i]          = d[0];
    in_tlast[i]          = l;
    in_tvalid[i]         = v;
  endtask

  task automatic clear_inputs();
    in_tdata   = '0;
    in_tkeep   = '0;
    in_tuser   = '0;
    in_tlast   = '0;
    in_tvalid  = '0;
    out_tready = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clear_inputs();
    tick();
    areset = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input int src, input logic [BW-1:0] d, input logic l);
    chk({tag, "_valid"}, 128'(out_tvalid), 128'(1'b1));
    chk({tag, "_tid"},   128'(out_tid),    128'(src));
    chk({tag, "_tdata"}, 128'(out_tdata),  128'(d));
    chk({tag, "_tkeep"}, 128'(out_tkeep),  128'(d[15:8]));
    chk({tag, "_tuser"}, 128'(out_tuser),  128'(d[0]));
    chk({tag, "_tlast"}, 128'(out_tlast),  128'(l));
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    areset = 1'b1;
    clear_inputs();
    tick();
    tick();
    areset = 1'b0;

    // Reset asserted in the middle of a packet on input 2
    drive(2, 1'b1, mk(2, 0), 1'b0);
    out_tready = 1'b1;
    #1 chk("t1_idle_valid", 128'(out_tvalid), 128'(0));
    tick();
    chk_beat("t1_b0", 2, mk(2, 0), 1'b0);
    chk("t1_b0_tready", 128'(in_tready), 128'(4'b0100));
    tick();
    drive(2, 1'b1, mk(2, 1), 1'b0);
    areset = 1'b1;
    #1;
    chk("t1_rst_tready", 128'(in_tready), 128'(0));
    chk("t1_rst_valid",  128'(out_tvalid), 128'(0));
    chk("t1_rst_cnt",    128'(pkt_count), 128'(0));
    chk("t1_rst_ptr",    128'(dut.r_rr_ptr), 128'(0));
    tick();
    chk("t1_rst_tready2", 128'(in_tready), 128'(0));
    chk("t1_rst_valid2",  128'(out_tvalid), 128'(0));
    clear_inputs();
    areset = 1'b0;

    // Single source: three-beat packet on input 1
    tick();
    drive(1, 1'b1, mk(1, 0), 1'b0);
    out_tready = 1'b1;
    #1 chk("t2_bubble", 128'(out_tvalid), 128'(0));
    tick();
    chk_beat("t2_b0", 1, mk(1, 0), 1'b0);
    chk("t2_tready", 128'(in_tready), 128'(4'b0010));
    tick();
    drive(1, 1'b1, mk(1, 1), 1'b0);
    #1 chk_beat("t2_b1", 1, mk(1, 1), 1'b0);
    tick();
    drive(1, 1'b1, mk(1, 2), 1'b1);
    #1 chk_beat("t2_b2", 1, mk(1, 2), 1'b1);
    tick();
    drive(1, 1'b0, mk(1, 3), 1'b0);
    #1;
    chk("t2_cnt",   128'(pkt_count), {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0});
    chk("t2_ptr",   128'(dut.r_rr_ptr), 128'(2));
    chk("t2_valid", 128'(out_tvalid), 128'(0));

    // All inputs valid with single-beat packets: strict rotation
    do_reset();
    mon_q.delete();
    for (int i = 0; i < 4; i++) drive(i, 1'b1, mk(i, 0), 1'b1);
    out_tready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("t3_bubble%0d", k), 128'(out_tvalid), 128'(0));
      tick();
      chk_beat($sformatf("t3_pkt%0d", k), k % 4, mk(k % 4, 0), 1'b1);
      chk($sformatf("t3_tready%0d", k), 128'(in_tready), 128'(4'b0001 << (k % 4)));
      tick();
    end
    clear_inputs();
    #1;
    chk("t3_beats", 128'(mon_q.size()), 128'(6));
    chk("t3_cnt", 128'(pkt_count), {32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2});
    chk("t3_ptr", 128'(dut.r_rr_ptr), 128'(2));

    // Stalls on both sides mid-packet; input 3 must wait for tlast
    do_reset();
    mon_q.delete();
    drive(0, 1'b1, mk(0, 0), 1'b0);
    drive(3, 1'b1, mk(3, 0), 1'b1);
    out_tready = 1'b1;
    #1 chk("t4_bubble", 128'(out_tvalid), 128'(0));
    tick();
    chk_beat("t4_b0", 0, mk(0, 0), 1'b0);
    tick();
    drive(0, 1'b1, mk(0, 1), 1'b0);
    out_tready = 1'b0;
    #1 chk_beat("t4_b1_stall", 0, mk(0, 1), 1'b0);
    chk("t4_tready_stall", 128'(in_tready), 128'(0));
    tick();
    out_tready = 1'b1;
    drive(0, 1'b0, mk(0, 1), 1'b0);
    #1 chk("t4_gap1_valid", 128'(out_tvalid), 128'(0));
    chk("t4_gap1_tid",    128'(out_tid), 128'(0));
    chk("t4_gap1_tready", 128'(in_tready), 128'(4'b0001));
    tick();
    chk("t4_gap2_valid", 128'(out_tvalid), 128'(0));
    chk("t4_gap2_tid",   128'(out_tid), 128'(0));
    tick();
    drive(0, 1'b1, mk(0, 1), 1'b0);
    #1 chk_beat("t4_b1", 0, mk(0, 1), 1'b0);
    tick();
    drive(0, 1'b1, mk(0, 2), 1'b1);
    #1 chk_beat("t4_b2", 0, mk(0, 2), 1'b1);
    tick();
    drive(0, 1'b0, mk(0, 3), 1'b0);
    #1 chk("t4_bubble2", 128'(out_tvalid), 128'(0));
    tick();
    chk_beat("t4_in3", 3, mk(3, 0), 1'b1);
    chk("t4_in3_tready", 128'(in_tready), 128'(4'b1000));
    tick();
    clear_inputs();
    #1;
    chk("t4_beats", 128'(mon_q.size()), 128'(4));
    if (mon_q.size() == 4) begin
      chk("t4_mon0", 128'(mon_q[0]), 128'({4'd0, 1'b0, mk(0, 0)}));
      chk("t4_mon1", 128'(mon_q[1]), 128'({4'd0, 1'b0, mk(0, 1)}));
      chk("t4_mon2", 128'(mon_q[2]), 128'({4'd0, 1'b1, mk(0, 2)}));
      chk("t4_mon3", 128'(mon_q[3]), 128'({4'd3, 1'b1, mk(3, 0)}));
    end
    chk("t4_cnt", 128'(pkt_count), {32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1});

    // Wrap-around search: rr_ptr=1 with inputs 0 and 3 requesting
    do_reset();
    drive(0, 1'b1, mk(0, 0), 1'b1);
    out_tready = 1'b1;
    tick();
    tick();
    drive(0, 1'b0, mk(0, 0), 1'b0);
    #1 chk("t5_ptr_pre", 128'(dut.r_rr_ptr), 128'(1));
    drive(0, 1'b1, mk(0, 1), 1'b1);
    drive(3, 1'b1, mk(3, 1), 1'b1);
    #1 chk("t5_bubble", 128'(out_tvalid), 128'(0));
    tick();
    chk_beat("t5_first", 3, mk(3, 1), 1'b1);
    tick();
    drive(3, 1'b0, mk(3, 1), 1'b0);
    #1 chk("t5_bubble2", 128'(out_tvalid), 128'(0));
    tick();
    chk_beat("t5_second", 0, mk(0, 1), 1'b1);
    tick();
    drive(0, 1'b0, mk(0, 1), 1'b0);
    #1;
    chk("t5_cnt", 128'(pkt_count), {32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd2});
    chk("t5_ptr", 128'(dut.r_rr_ptr), 128'(1));

    // Counter wrap on input 2
    force dut.r_pkt_count = {32'd1, 32'hFFFF_FFFF, 32'd0, 32'd2};
    #1;
    release dut.r_pkt_count;
    #1 chk("t6_preload", 128'(pkt_count[95:64]), 128'(32'hFFFF_FFFF));
    drive(2, 1'b1, mk(2, 5), 1'b1);
    tick();
    chk_beat("t6_pkt", 2, mk(2, 5), 1'b1);
    tick();
    drive(2, 1'b0, mk(2, 5), 1'b0);
    #1;
    chk("t6_wrap", 128'(pkt_count), {32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd2});
    chk("t6_ptr",  128'(dut.r_rr_ptr), 128'(3));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
